// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and validity helper for the decade-counter datapath.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // True when the nibble is a legal decimal digit (0..9).
    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with in-place up/down wrap and synchronous load.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic       up,
    input  logic       load,
    input  bcd_digit_t ld_digit,
    output bcd_digit_t q,
    output logic       at_max,
    output logic       at_min
);

    bcd_digit_t r_q;
    bcd_digit_t w_next;

    // Next value for a stepping digit: wraps 9->0 counting up, 0->9 counting down.
    always_comb begin
        w_next = r_q;
        if (up) begin
            w_next = (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
        end else begin
            w_next = (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
        end
    end

    // Digit register: reset beats load, load beats step, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= BCD_MIN;
        end else if (load) begin
            r_q <= ld_digit;
        end else if (step) begin
            r_q <= w_next;
        end
    end

    assign q      = r_q;
    assign at_max = (r_q == BCD_MAX);
    assign at_min = (r_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter.sv
// Cascadable N-digit BCD up/down counter with sanitised parallel load,
// sticky load-error flag and combinational terminal count.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  clr_err,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  load_err
);

    logic [DIGITS-1:0]   w_step;
    logic [DIGITS-1:0]   w_at_max;
    logic [DIGITS-1:0]   w_at_min;
    logic [DIGITS-1:0]   w_bad;
    logic [4*DIGITS-1:0] w_ld_clean;
    logic                w_run;
    logic                r_load_err;

    // Load sanitising: any nibble above 9 is replaced by 0 and flagged.
    always_comb begin
        w_ld_clean = '0;
        w_bad      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (is_bcd(load_val[4*i +: 4])) begin
                w_ld_clean[4*i +: 4] = load_val[4*i +: 4];
            end else begin
                w_bad[i] = 1'b1;
            end
        end
    end

    // Ripple step chain: a digit steps when en is high and every lower digit is at its wrap value.
    always_comb begin
        w_step = '0;
        w_run  = en;
        for (int i = 0; i < DIGITS; i++) begin
            w_step[i] = w_run;
            w_run     = w_run & (up ? w_at_max[i] : w_at_min[i]);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .step     (w_step[g]),
            .up       (up),
            .load     (load),
            .ld_digit (w_ld_clean[4*g +: 4]),
            .q        (count[4*g +: 4]),
            .at_max   (w_at_max[g]),
            .at_min   (w_at_min[g])
        );
    end

    // Sticky load-error flag: a bad-digit load sets it and wins over a same-edge clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_err <= 1'b0;
        end else if (load && (|w_bad)) begin
            r_load_err <= 1'b1;
        end else if (clr_err) begin
            r_load_err <= 1'b0;
        end
    end

    assign load_err = r_load_err;
    assign tc       = en & ~load & (up ? (&w_at_max) : (&w_at_min));

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter (DIGITS=4): directed scenarios plus random traffic
// compared against a decimal-integer reference model.
module tb_bcd_counter;

    localparam int DIGITS = 4;
    localparam int MODULUS = 10000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic        clr_err;
    logic [15:0] count;
    logic        tc;
    logic        load_err;

    int n_chk;
    int n_err;

    // Reference model state: counter value as a plain decimal integer.
    int  m_val;
    logic m_err;

    bcd_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .clr_err  (clr_err),
        .count    (count),
        .tc       (tc),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // One clock cycle: drive inputs, check tc before the edge, update model, check registers after.
    task automatic cyc(input logic i_rst_n, input logic i_en, input logic i_up,
                       input logic i_load, input logic [15:0] i_lv, input logic i_clr);
        int  nv;
        int  mul;
        logic bad;
        logic [3:0] nib;
        logic exp_tc;
        rst_n    = i_rst_n;
        en       = i_en;
        up       = i_up;
        load     = i_load;
        load_val = i_lv;
        clr_err  = i_clr;
        #2;
        exp_tc = i_en & ~i_load & (i_up ? (m_val == MODULUS - 1) : (m_val == 0));
        check("tc", {31'd0, tc}, {31'd0, exp_tc});
        @(posedge clk);
        if (!i_rst_n) begin
            m_val = 0;
            m_err = 1'b0;
        end else if (i_load) begin
            nv  = 0;
            mul = 1;
            bad = 1'b0;
            for (int d = 0; d < DIGITS; d++) begin
                nib = i_lv[4*d +: 4];
                if (nib > 4'd9) begin
                    bad = 1'b1;
                    nib = 4'd0;
                end
                nv  = nv + int'(nib) * mul;
                mul = mul * 10;
            end
            m_val = nv;
            if (bad) m_err = 1'b1;
            else if (i_clr) m_err = 1'b0;
        end else begin
            if (i_en) m_val = i_up ? (m_val + 1) % MODULUS : (m_val + MODULUS - 1) % MODULUS;
            if (i_clr) m_err = 1'b0;
        end
        #1;
        check("count", {16'd0, count}, {16'd0, to_bcd(m_val)});
        check("load_err", {31'd0, load_err}, {31'd0, m_err});
    endtask

    initial begin
        logic [15:0] lv;
        n_chk = 0;
        n_err = 0;
        m_val = 0;
        m_err = 1'b0;
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; clr_err = 1'b0;

        // Reset held with counting requested.
        repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("reset_count", {16'd0, count}, 32'h0000);
        repeat (10) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("ten_up", {16'd0, count}, 32'h0010);

        // Full wrap upward.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h9998, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("at_9999", {16'd0, count}, 32'h9999);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("wrap_up", {16'd0, count}, 32'h0000);

        // Full wrap downward, then direction change.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("wrap_down", {16'd0, count}, 32'h9999);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("dir_change", {16'd0, count}, 32'h0000);

        // Bad-digit load, stickiness, clear, set-beats-clear.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h12A4, 1'b0);
        check("sanitise", {16'd0, count}, 32'h1204);
        check("err_set", {31'd0, load_err}, 32'd1);
        repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        check("err_clr", {31'd0, load_err}, 32'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'hF000, 1'b1);
        check("set_wins", {31'd0, load_err}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);

        // Load beats enable; hold when disabled.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0500, 1'b0);
        check("load_over_en", {16'd0, count}, 32'h0500);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("hold", {16'd0, count}, 32'h0500);

        // Reset beats load mid-count.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0030, 1'b0);
        repeat (7) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("at_0037", {16'd0, count}, 32'h0037);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h4444, 1'b0);
        check("rst_over_load", {16'd0, count}, 32'h0000);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("resume", {16'd0, count}, 32'h0001);

        // Random traffic; loads are biased toward wrap points so carries and borrows ripple.
        for (int k = 0; k < 400; k++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            case ($urandom_range(0, 3))
                0: lv = 16'h9999;
                1: lv = 16'h0000;
                2: lv = to_bcd(int'($urandom_range(0, MODULUS - 1)));
                default: lv = 16'($urandom);
            endcase
            cyc(sel != 0, $urandom_range(0, 9) < 7, 1'($urandom), sel >= 90, lv,
                $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
